mem_addr_ctrl: RTL and testbench

Parametrised memory-address source controller for the multicycle MIPS datapath. It replaces the fixed IorD select with a registered address register.
- Normal operation: selects one of N_SRC general address sources (PC, ALUOut, …).
- On an exception request: an internal FSM drives the exception-vector byte address (VEC_BASE+cause), waits the memory read latency, and returns the fetched byte as the handler PC.
- Sits between the control unit, the exception sources and the memory address port.

---
 rtl/mem_addr_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_addr_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_ctrl.sv
// Memory-address source controller for the multicycle MIPS datapath.
//
// Drives a registered memory address. In normal operation it loads one of
// N_SRC general address sources. On an exception request it fetches the
// handler byte from the exception vector table (VEC_BASE + cause) and returns
// it as the handler PC.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-high reset
//   src_bus    flattened address sources, source k = [k*WIDTH +: WIDTH]
//   src_sel    general source select (out-of-range selects address 0)
//   addr_hold  keep addr_out unchanged while idle
//   exc_req    level exception requests, held until acknowledged
//   mem_rdata  byte read from memory (vector content)
//   addr_out   registered memory address
//   busy       vector fetch in progress
//   vec_valid  one-cycle pulse: vec_pc / exc_cause valid
//   vec_pc     handler PC, zero-extended mem_rdata
//   exc_cause  index of the serviced cause
//   exc_ack    one-hot acknowledge, pulses with vec_valid
module mem_addr_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SRC    = 2,
    parameter int unsigned SEL_W    = 1,
    parameter int unsigned N_EXC    = 3,
    parameter int unsigned CAUSE_W  = 2,
    parameter int unsigned VEC_BASE = 253,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH*N_SRC-1:0] src_bus,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic                   addr_hold,
    input  logic [N_EXC-1:0]       exc_req,
    input  logic [7:0]             mem_rdata,
    output logic [WIDTH-1:0]       addr_out,
    output logic                   busy,
    output logic                   vec_valid,
    output logic [WIDTH-1:0]       vec_pc,
    output logic [CAUSE_W-1:0]     exc_cause,
    output logic [N_EXC-1:0]       exc_ack
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               vec_valid_q, vec_valid_d;
    logic [WIDTH-1:0]   vec_pc_q, vec_pc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [N_EXC-1:0]   ack_q, ack_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               req_any;
    logic [CAUSE_W-1:0] req_idx;
    logic [WIDTH-1:0]   src_val;
    logic               start_fetch;
    logic               fetch_done;

    // Lowest set request index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        req_any = |exc_req;
        req_idx = '0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (exc_req[i]) begin
                req_idx = CAUSE_W'(i);
            end
        end
    end

    // Source mux; any select without a matching source yields address 0.
    always_comb begin
        src_val = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                src_val = src_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // vec_valid_q doubles as the holdoff flag so a just-acked request cannot re-fire.
    assign start_fetch = (state_q == StIdle) && req_any && !vec_valid_q;
    assign fetch_done  = (state_q == StFetch) && (cnt_q == CNT_W'(1));

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_pc_q    <= '0;
            cause_q     <= '0;
            ack_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            vec_valid_q <= vec_valid_d;
            vec_pc_q    <= vec_pc_d;
            cause_q     <= cause_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_fetch) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (fetch_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        addr_d      = addr_q;
        busy_d      = busy_q;
        vec_valid_d = 1'b0;
        vec_pc_d    = vec_pc_q;
        cause_d     = cause_q;
        ack_d       = '0;
        cnt_d       = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_fetch) begin
                    addr_d  = WIDTH'(VEC_BASE) + WIDTH'(req_idx);
                    cause_d = req_idx;
                    cnt_d   = CNT_W'(MEM_LAT);
                    busy_d  = 1'b1;
                end else if (!addr_hold) begin
                    addr_d = src_val;
                end
            end
            StFetch: begin
                if (fetch_done) begin
                    vec_pc_d    = WIDTH'(mem_rdata);
                    vec_valid_d = 1'b1;
                    ack_d       = N_EXC'(1) << cause_q;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign addr_out  = addr_q;
    assign busy      = busy_q;
    assign vec_valid = vec_valid_q;
    assign vec_pc    = vec_pc_q;
    assign exc_cause = cause_q;
    assign exc_ack   = ack_q;

endmodule

// File: tb/tb_mem_addr_ctrl.sv
// Scoreboard bench for mem_addr_ctrl. Two instances: dut0 (N_SRC=2, MEM_LAT=1)
// and dut1 (N_SRC=1, MEM_LAT=3). The memory model only returns the true vector
// byte when the address has been stable for exactly MEM_LAT edges at sampling.
module tb_mem_addr_ctrl;

    localparam int unsigned VEC_BASE = 253;

    typedef struct {
        int          dut;
        int          kind;  // 0 address at cycle, 1 vector result, 2 reset state at cycle
        int          cyc;
        logic [31:0] val;
        logic [1:0]  cause;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        src_sel   [2];
    logic        addr_hold [2];
    logic [2:0]  exc_req   [2];
    logic [7:0]  mem_rdata [2];
    logic [63:0] src_bus0;
    logic [31:0] src_bus1;

    logic [31:0] addr_out  [2];
    logic        busy      [2];
    logic        vec_valid [2];
    logic [31:0] vec_pc    [2];
    logic [1:0]  exc_cause [2];
    logic [2:0]  exc_ack   [2];

    logic [31:0] d0_addr, d1_addr, d0_pc, d1_pc;
    logic        d0_busy, d1_busy, d0_vv, d1_vv;
    logic [1:0]  d0_cause, d1_cause;
    logic [2:0]  d0_ack, d1_ack;

    logic [7:0]  mem [256];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stable    [2];
    logic [31:0] last_addr [2];
    int          busy_run  [2];
    logic        prev_valid[2];
    logic [31:0] model     [2];

    mem_addr_ctrl #(
        .WIDTH(32), .N_SRC(2), .SEL_W(1), .N_EXC(3), .CAUSE_W(2),
        .VEC_BASE(VEC_BASE), .MEM_LAT(1)
    ) u_dut0 (
        .clk(clk), .reset(rst[0]), .src_bus(src_bus0), .src_sel(src_sel[0]),
        .addr_hold(addr_hold[0]), .exc_req(exc_req[0]), .mem_rdata(mem_rdata[0]),
        .addr_out(d0_addr), .busy(d0_busy), .vec_valid(d0_vv), .vec_pc(d0_pc),
        .exc_cause(d0_cause), .exc_ack(d0_ack)
    );

    mem_addr_ctrl #(
        .WIDTH(32), .N_SRC(1), .SEL_W(1), .N_EXC(3), .CAUSE_W(2),
        .VEC_BASE(VEC_BASE), .MEM_LAT(3)
    ) u_dut1 (
        .clk(clk), .reset(rst[1]), .src_bus(src_bus1), .src_sel(src_sel[1]),
        .addr_hold(addr_hold[1]), .exc_req(exc_req[1]), .mem_rdata(mem_rdata[1]),
        .addr_out(d1_addr), .busy(d1_busy), .vec_valid(d1_vv), .vec_pc(d1_pc),
        .exc_cause(d1_cause), .exc_ack(d1_ack)
    );

    always_comb begin
        addr_out[0] = d0_addr;  addr_out[1] = d1_addr;
        busy[0]     = d0_busy;  busy[1]     = d1_busy;
        vec_valid[0] = d0_vv;   vec_valid[1] = d1_vv;
        vec_pc[0]   = d0_pc;    vec_pc[1]   = d1_pc;
        exc_cause[0] = d0_cause; exc_cause[1] = d1_cause;
        exc_ack[0]  = d0_ack;   exc_ack[1]  = d1_ack;
    end

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nsrc_of(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Latency-exact memory: wrong data unless sampled MEM_LAT edges after the address.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            if (stable[d] == lat_of(d) - 1) mem_rdata[d] = mem[addr_out[d][7:0]];
            else                            mem_rdata[d] = ~mem[addr_out[d][7:0]];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got 0x%08h required 0x%08h",
                     name, d, cyc, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int idx;
                int f;
                idx = 0;
                while (idx < sb.size()) begin
                    if (sb[idx].dut == d && sb[idx].kind != 1 && sb[idx].cyc == cyc) begin
                        if (sb[idx].kind == 0) begin
                            check("addr_out", d, addr_out[d], sb[idx].val);
                        end else begin
                            check("rst_addr", d, addr_out[d], 32'h0);
                            check("rst_busy", d, 32'(busy[d]), 32'h0);
                            check("rst_valid", d, 32'(vec_valid[d]), 32'h0);
                            check("rst_pc", d, vec_pc[d], 32'h0);
                            check("rst_cause", d, 32'(exc_cause[d]), 32'h0);
                            check("rst_ack", d, 32'(exc_ack[d]), 32'h0);
                        end
                        sb.delete(idx);
                    end else begin
                        idx++;
                    end
                end
                if (rst[d]) begin
                    busy_run[d]   = 0;
                    prev_valid[d] = 1'b0;
                end else begin
                    if (busy[d]) begin
                        busy_run[d]++;
                        check("vec_addr", d, addr_out[d], VEC_BASE + 32'(exc_cause[d]));
                    end
                    if (vec_valid[d]) begin
                        f = -1;
                        for (int j = 0; j < sb.size(); j++) begin
                            if (f < 0 && sb[j].dut == d && sb[j].kind == 1) f = j;
                        end
                        if (f < 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_vec dut%0d cyc %0d: got cause %0d required none",
                                     d, cyc, exc_cause[d]);
                        end else begin
                            check("exc_cause", d, 32'(exc_cause[d]), 32'(sb[f].cause));
                            check("vec_pc", d, vec_pc[d], sb[f].val);
                            check("exc_ack", d, 32'(exc_ack[d]), 32'(3'b001 << sb[f].cause));
                            check("fetch_len", d, busy_run[d], lat_of(d));
                            check("valid_pulse", d, 32'(prev_valid[d]), 32'h0);
                            check("busy_at_valid", d, 32'(busy[d]), 32'h0);
                            sb.delete(f);
                        end
                        busy_run[d] = 0;
                    end else begin
                        check("ack_idle", d, 32'(exc_ack[d]), 32'h0);
                    end
                    prev_valid[d] = vec_valid[d];
                end
                if (addr_out[d] != last_addr[d]) begin
                    stable[d]    = 0;
                    last_addr[d] = addr_out[d];
                end else begin
                    stable[d]++;
                end
            end
        end
    end

    function automatic int pending_vec(int d);
        int n = 0;
        foreach (sb[j]) if (sb[j].dut == d && sb[j].kind == 1) n++;
        return n;
    endfunction

    function automatic logic [31:0] src_of(int d, logic sel);
        if (d == 1) return src_bus1;
        return sel ? src_bus0[63:32] : src_bus0[31:0];
    endfunction

    // One falling edge; the requester drops any bit acknowledged this cycle.
    task automatic step();
        @(negedge clk);
        exc_req[0] = exc_req[0] & ~exc_ack[0];
        exc_req[1] = exc_req[1] & ~exc_ack[1];
    endtask

    task automatic addr_step(input int d, input logic sel, input logic hold, input bit rnd);
        exp_t e;
        step();
        if (rnd) begin
            src_bus0 = {$urandom & 32'hFFFF_FFF0, $urandom & 32'hFFFF_FFF0};
            src_bus1 = $urandom & 32'hFFFF_FFF0;
        end
        src_sel[d]   = sel;
        addr_hold[d] = hold;
        if (!hold) model[d] = (int'(sel) < nsrc_of(d)) ? src_of(d, sel) : 32'h0;
        e.dut = d; e.kind = 0; e.cyc = cyc + 1; e.val = model[d]; e.cause = 2'd0;
        sb.push_back(e);
    endtask

    task automatic raise(input int d, input logic [2:0] mask, input bit rnd_mem);
        exp_t e;
        step();
        if (rnd_mem) begin
            for (int i = 0; i < 3; i++) mem[VEC_BASE + i] = 8'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                e.dut = d; e.kind = 1; e.cyc = 0; e.cause = 2'(i);
                e.val = {24'h0, mem[VEC_BASE + i]};
                sb.push_back(e);
            end
        end
        addr_hold[d] = 1'b0;
        exc_req[d]   = mask;
    endtask

    // Wait until every request is acknowledged, toggling src_sel (must be ignored).
    task automatic wait_idle(input int d);
        bit done = 0;
        for (int n = 0; n < 60 && !done; n++) begin
            step();
            src_sel[d]   = 1'($urandom);
            addr_hold[d] = 1'b0;
            if (exc_req[d] == 3'b000 && !busy[d] && pending_vec(d) == 0) done = 1;
        end
        if (!done) begin
            $display("FAIL wait_idle dut%0d: outstanding %0d req %03b required 0",
                     d, pending_vec(d), exc_req[d]);
            $fatal(1, "bound expired");
        end
        step();
    endtask

    task automatic push_rst_check(input int d);
        exp_t e;
        e.dut = d; e.kind = 2; e.cyc = cyc; e.val = 32'h0; e.cause = 2'd0;
        sb.push_back(e);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'($urandom);
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; src_sel[d] = 1'b0; addr_hold[d] = 1'b0; exc_req[d] = 3'b000;
            stable[d] = 0; last_addr[d] = 32'h0; busy_run[d] = 0; prev_valid[d] = 1'b0;
            model[d] = 32'h0;
        end
        src_bus0 = {32'h0000_1000, 32'h0000_0040};
        src_bus1 = 32'h0000_0040;
        @(posedge clk);
        #1;
        push_rst_check(0);
        push_rst_check(1);
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Source selection and hold.
        addr_step(0, 1'b0, 1'b0, 0);
        addr_step(0, 1'b1, 1'b0, 0);
        addr_step(0, 1'b0, 1'b1, 0);
        addr_step(0, 1'b1, 1'b1, 0);
        addr_step(0, 1'b0, 1'b1, 0);
        // Single request, then two simultaneous ones serviced in priority order.
        mem[254] = 8'h7C;
        raise(0, 3'b010, 0);
        wait_idle(0);
        raise(0, 3'b110, 1);
        wait_idle(0);

        // Out-of-range select on the single-source instance.
        addr_step(1, 1'b0, 1'b0, 0);
        addr_step(1, 1'b1, 1'b0, 0);
        addr_step(1, 1'b0, 1'b0, 0);
        raise(1, 3'b001, 1);
        wait_idle(1);

        // Reset mid-fetch: outputs clear before the next edge, fetch restarts after.
        raise(1, 3'b001, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        push_rst_check(1);
        step();
        step();
        rst[1] = 1'b0;
        wait_idle(1);

        // Randomised mix of address traffic and request sets on both instances.
        for (int it = 0; it < 15; it++) begin
            for (int d = 0; d < 2; d++) begin
                int n = 2 + int'($urandom_range(3));
                addr_step(d, 1'($urandom), 1'b0, 1);
                for (int k = 0; k < n; k++) addr_step(d, 1'($urandom), 1'($urandom), 1);
                raise(d, 3'($urandom_range(7, 1)), 1);
                wait_idle(d);
            end
        end

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
